// File: rtl/gemm_tile_scheduler.sv
// GEMM tile-loop sequencer: weight preload, ifmap streaming and accumulator drain per N/K tile.
// Optional layer cycle counter is enabled by defining GEMM_SCHED_PERF_CNT_EN.
module gemm_tile_scheduler #(
  parameter int PE_SIZE    = 14,
  parameter int K_TILES    = 21,
  parameter int N_TILES    = 5,
  parameter int M_ROWS     = 16,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         drain_ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         wmem_ce_o,
  output logic [ADDR_WIDTH-1:0]        wmem_addr_o,
  output logic                         imem_ce_o,
  output logic [ADDR_WIDTH-1:0]        imem_addr_o,
  output logic [PE_SIZE-1:0]           weight_en_col_o,
  output logic                         psum_en_o,
  output logic                         acc_wren_o,
  output logic                         acc_rden_o,
  output logic [$clog2(K_TILES):0]     k_tile_o,
  output logic [$clog2(N_TILES):0]     n_tile_o,
  output logic [31:0]                  cycle_cnt_o
);

  localparam int STREAM_LEN = M_ROWS + 2*PE_SIZE - 1;
  localparam int KW = $clog2(K_TILES) + 1;
  localparam int NW = $clog2(N_TILES) + 1;
  localparam int JW = $clog2(PE_SIZE + 1);
  localparam int SW = $clog2(STREAM_LEN + 1);
  localparam int DW = $clog2(M_ROWS + 1);

  typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [JW-1:0]         j_reg, j_next;
  logic [SW-1:0]         s_reg, s_next;
  logic [DW-1:0]         d_reg, d_next;
  logic [KW-1:0]         k_reg, k_next;
  logic [NW-1:0]         n_reg, n_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [ADDR_WIDTH-1:0] ibase_reg, ibase_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      j_reg     <= '0;
      s_reg     <= '0;
      d_reg     <= '0;
      k_reg     <= '0;
      n_reg     <= '0;
      waddr_reg <= '0;
      ibase_reg <= '0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      s_reg     <= s_next;
      d_reg     <= d_next;
      k_reg     <= k_next;
      n_reg     <= n_next;
      waddr_reg <= waddr_next;
      ibase_reg <= ibase_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    j_next          = j_reg;
    s_next          = s_reg;
    d_next          = d_reg;
    k_next          = k_reg;
    n_next          = n_reg;
    waddr_next      = waddr_reg;
    ibase_next      = ibase_reg;
    done_o          = 1'b0;
    wmem_ce_o       = 1'b0;
    wmem_addr_o     = '0;
    imem_ce_o       = 1'b0;
    imem_addr_o     = '0;
    weight_en_col_o = '0;
    psum_en_o       = 1'b0;
    acc_wren_o      = 1'b0;
    acc_rden_o      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next = WLOAD;
          j_next     = '0;
          k_next     = '0;
          n_next     = '0;
          waddr_next = '0;
          ibase_next = '0;
        end
      end

      WLOAD: begin
        if (j_reg < JW'(PE_SIZE)) begin
          wmem_ce_o   = 1'b1;
          wmem_addr_o = waddr_reg;
          waddr_next  = waddr_reg + 1'b1;
        end
        // Column enable trails the address by one cycle to match buffer read latency.
        if (j_reg != '0)
          weight_en_col_o = PE_SIZE'(1) << (j_reg - 1'b1);
        if (j_reg == JW'(PE_SIZE)) begin
          j_next     = '0;
          s_next     = '0;
          state_next = STREAM;
        end else begin
          j_next = j_reg + 1'b1;
        end
      end

      STREAM: begin
        if (s_reg < SW'(M_ROWS)) begin
          imem_ce_o   = 1'b1;
          imem_addr_o = ibase_reg + ADDR_WIDTH'(s_reg);
        end
        psum_en_o  = (s_reg >= SW'(1)) && (s_reg <= SW'(M_ROWS));
        acc_wren_o = (s_reg >= SW'(2*PE_SIZE-1)) && (s_reg <= SW'(2*PE_SIZE-2+M_ROWS));
        if (s_reg == SW'(STREAM_LEN-1)) begin
          s_next = '0;
          if (k_reg < KW'(K_TILES-1)) begin
            k_next     = k_reg + 1'b1;
            ibase_next = ibase_reg + ADDR_WIDTH'(M_ROWS);
            state_next = WLOAD;
          end else begin
            d_next     = '0;
            state_next = DRAIN;
          end
        end else begin
          s_next = s_reg + 1'b1;
        end
      end

      DRAIN: begin
        acc_rden_o = drain_ready_i;
        if (drain_ready_i) begin
          if (d_reg == DW'(M_ROWS-1)) begin
            d_next = '0;
            if (n_reg < NW'(N_TILES-1)) begin
              n_next     = n_reg + 1'b1;
              k_next     = '0;
              ibase_next = '0;
              state_next = WLOAD;
            end else begin
              state_next = DONE;
            end
          end else begin
            d_next = d_reg + 1'b1;
          end
        end
      end

      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy_o   = (state_reg != IDLE);
  assign k_tile_o = k_reg;
  assign n_tile_o = n_reg;

`ifdef GEMM_SCHED_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)
      cycle_cnt_reg <= '0;
    else if (state_reg == IDLE && start_i)
      cycle_cnt_reg <= '0;
    else if (state_reg != IDLE)
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
  end

  assign cycle_cnt_o = cycle_cnt_reg;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler with PE_SIZE=4, K_TILES=2, N_TILES=2, M_ROWS=3.
// Expected cycle_cnt_o follows GEMM_SCHED_PERF_CNT_EN.
module tb_gemm_tile_scheduler;
  localparam int PE = 4;
  localparam int KT = 2;
  localparam int NT = 2;
  localparam int MR = 3;
  localparam int AW = 13;
  localparam int SLEN = 10;          // M + 2*PE - 1
  localparam int LAYER_CYCLES = 67;  // 2*(2*(12+3)+3)+1

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          drain_ready_i;
  logic          busy_o;
  logic          done_o;
  logic          wmem_ce_o;
  logic [AW-1:0] wmem_addr_o;
  logic          imem_ce_o;
  logic [AW-1:0] imem_addr_o;
  logic [PE-1:0] weight_en_col_o;
  logic          psum_en_o;
  logic          acc_wren_o;
  logic          acc_rden_o;
  logic [1:0]    k_tile_o;
  logic [1:0]    n_tile_o;
  logic [31:0]   cycle_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  gemm_tile_scheduler #(
    .PE_SIZE(PE), .K_TILES(KT), .N_TILES(NT), .M_ROWS(MR), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .drain_ready_i(drain_ready_i),
    .busy_o(busy_o), .done_o(done_o),
    .wmem_ce_o(wmem_ce_o), .wmem_addr_o(wmem_addr_o),
    .imem_ce_o(imem_ce_o), .imem_addr_o(imem_addr_o),
    .weight_en_col_o(weight_en_col_o), .psum_en_o(psum_en_o),
    .acc_wren_o(acc_wren_o), .acc_rden_o(acc_rden_o),
    .k_tile_o(k_tile_o), .n_tile_o(n_tile_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return 64'({busy_o, done_o, wmem_ce_o, wmem_addr_o, imem_ce_o, imem_addr_o,
                weight_en_col_o, psum_en_o, acc_wren_o, acc_rden_o, k_tile_o, n_tile_o});
  endfunction

  function automatic logic [63:0] exp_vec(bit busy, bit done, bit wce, int waddr, bit ice,
                                          int iaddr, int wen, bit psum, bit wren, bit rden,
                                          int k, int n);
    return 64'({busy, done, wce, 13'(waddr), ice, 13'(iaddr), 4'(wen), psum, wren, rden,
                2'(k), 2'(n)});
  endfunction

  function automatic logic [31:0] exp_cnt(int cycles);
`ifdef GEMM_SCHED_PERF_CNT_EN
    return 32'(cycles);
`else
    return 32'(cycles * 0);
`endif
  endfunction

  // One full layer from an IDLE cycle, with optional DRAIN stall in the first N tile.
  task automatic run_layer(input int stall, input bit hold);
    int busy_seen;
    bit rd;
    busy_seen = 0;
    start_i = 1'b1;
    drain_ready_i = 1'b1;
    tick();
    start_i = hold;
    for (int n = 0; n < NT; n++) begin
      for (int k = 0; k < KT; k++) begin
        for (int j = 0; j <= PE; j++) begin
          #1;
          chk("wload", obs_vec(), exp_vec(1, 0, j < PE, (j < PE) ? (n*KT + k)*PE + j : 0, 0, 0,
                                          (j >= 1) ? (1 << (j-1)) : 0, 0, 0, 0, k, n));
          busy_seen += int'(busy_o);
          tick();
        end
        for (int s = 0; s < SLEN; s++) begin
          #1;
          chk("stream", obs_vec(), exp_vec(1, 0, 0, 0, s < MR, (s < MR) ? k*MR + s : 0, 0,
                                           (s >= 1 && s <= 3), (s >= 7 && s <= 9), 0, k, n));
          busy_seen += int'(busy_o);
          tick();
        end
      end
      for (int c = 0; c < ((n == 0) ? stall : 0) + MR; c++) begin
        rd = !(n == 0 && c < stall);
        drain_ready_i = rd;
        #1;
        chk("drain", obs_vec(), exp_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, rd, KT-1, n));
        busy_seen += int'(busy_o);
        tick();
      end
      drain_ready_i = 1'b1;
    end
    #1;
    chk("done", obs_vec(), exp_vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, KT-1, NT-1));
    busy_seen += int'(busy_o);
    tick();
    #1;
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("idle_done", 64'(done_o), 64'(0));
    chk("busy_len", 64'(busy_seen), 64'(LAYER_CYCLES + stall));
    chk("cycle_cnt", 64'(cycle_cnt_o), 64'(exp_cnt(LAYER_CYCLES + stall)));
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    drain_ready_i = 1'b1;
    tick();
    tick();
    chk("reset_out", obs_vec(), 64'(0));
    chk("reset_cnt", 64'(cycle_cnt_o), 64'(0));
    rst = 1'b0;
    tick();
    #1;
    chk("idle_after_reset", obs_vec(), 64'(0));

    run_layer(0, 1'b0);
    start_i = 1'b0;
    tick();
    tick();
    run_layer(5, 1'b0);

    // Abort mid-STREAM, then confirm a clean restart.
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < PE + 1 + 3; c++) tick();
    #1;
    chk("mid_stream", obs_vec(), exp_vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_out", obs_vec(), 64'(0));
    chk("abort_cnt", 64'(cycle_cnt_o), 64'(0));
    tick();
    #1;
    chk("abort_idle", obs_vec(), 64'(0));
    run_layer(0, 1'b0);

    // start_i held high: one layer, then the next begins right after IDLE.
    run_layer(0, 1'b1);
    run_layer(0, 1'b0);
    start_i = 1'b0;
    tick();
    #1;
    chk("final_idle", obs_vec(), exp_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, KT-1, NT-1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
